// File: rtl/gcn_pkg.sv
// Shared GCN datapath constants and types used by the result streamer.
package gcn_pkg;

   localparam int unsigned NUM_NODES   = 6;
   localparam int unsigned NUM_CLASSES = 3;
   localparam int unsigned IDX_W       = 3;
   localparam int unsigned ADDR_W      = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

   typedef logic [IDX_W-1:0]  class_idx_t;
   typedef logic [ADDR_W-1:0] node_addr_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } stream_state_t;

   localparam node_addr_t LAST_NODE = node_addr_t'(NUM_NODES - 1);

   // True when an index falls outside the legal class range.
   function automatic logic class_illegal(input class_idx_t c);
      return c >= class_idx_t'(NUM_CLASSES);
   endfunction

   // True when a lane address names a real node.
   function automatic logic addr_in_range(input node_addr_t a);
      return a <= LAST_NODE;
   endfunction

endpackage

// File: rtl/class_result_streamer.sv
// Captures one arg-max class-index burst and streams it out in node order.
module class_result_streamer
   import gcn_pkg::*;
(
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                wr_en,
   input  logic [NUM_NODES-1:0][ADDR_W-1:0]    wr_addr,
   input  logic [NUM_NODES-1:0][IDX_W-1:0]     wr_data,
   output logic                                rd_valid,
   input  logic                                rd_ready,
   output logic [ADDR_W-1:0]                   rd_node,
   output logic [IDX_W-1:0]                    rd_class,
   output logic                                rd_last,
   output logic                                busy,
   output logic                                stream_done,
   output logic                                err_class,
   output logic                                overrun
);

   stream_state_t state_q, state_d;
   node_addr_t    ptr_q, ptr_d;
   class_idx_t    mem_q [NUM_NODES];
   class_idx_t    mem_d [NUM_NODES];
   logic          err_d;
   logic          handshake;

   logic          rd_valid_d;
   node_addr_t    rd_node_d;
   class_idx_t    rd_class_d;
   logic          rd_last_d;
   logic          busy_d;
   logic          stream_done_d;
   logic          overrun_d;

   assign handshake = rd_valid & rd_ready;

   // Next-state, capture and next-output logic.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      err_d         = err_class;
      overrun_d     = 1'b0;
      for (int n = 0; n < int'(NUM_NODES); n++) begin
         mem_d[n] = mem_q[n];
      end

      case (state_q)
         IDLE: begin
            if (wr_en) begin
               state_d = STREAM;
               ptr_d   = '0;
               err_d   = 1'b0;
               // Ascending lane order lets the highest lane win on duplicates.
               for (int i = 0; i < int'(NUM_NODES); i++) begin
                  if (addr_in_range(wr_addr[i])) begin
                     mem_d[wr_addr[i]] = wr_data[i];
                     if (class_illegal(wr_data[i])) begin
                        err_d = 1'b1;
                     end
                  end
               end
            end
         end
         STREAM: begin
            overrun_d = wr_en;
            if (handshake) begin
               if (ptr_q == LAST_NODE) begin
                  state_d = DONE;
               end else begin
                  ptr_d = ADDR_W'(ptr_q + 1'b1);
               end
            end
         end
         DONE: begin
            overrun_d = wr_en;
            state_d   = IDLE;
            ptr_d     = '0;
         end
         default: begin
            state_d = IDLE;
            ptr_d   = '0;
         end
      endcase

      rd_valid_d    = (state_d == STREAM);
      rd_node_d     = rd_valid_d ? ptr_d : '0;
      rd_class_d    = rd_valid_d ? mem_d[ptr_d] : '0;
      rd_last_d     = rd_valid_d && (ptr_d == LAST_NODE);
      busy_d        = (state_d != IDLE);
      stream_done_d = (state_d == DONE);
   end

   // State, pointer and result storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         for (int n = 0; n < int'(NUM_NODES); n++) begin
            mem_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         for (int n = 0; n < int'(NUM_NODES); n++) begin
            mem_q[n] <= mem_d[n];
         end
      end
   end

   // Registered outputs, aligned with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid    <= 1'b0;
         rd_node     <= '0;
         rd_class    <= '0;
         rd_last     <= 1'b0;
         busy        <= 1'b0;
         stream_done <= 1'b0;
         err_class   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         rd_valid    <= rd_valid_d;
         rd_node     <= rd_node_d;
         rd_class    <= rd_class_d;
         rd_last     <= rd_last_d;
         busy        <= busy_d;
         stream_done <= stream_done_d;
         err_class   <= err_d;
         overrun     <= overrun_d;
      end
   end

endmodule

// File: tb/tb_class_result_streamer.sv
// Self-checking bench for class_result_streamer: hand vectors plus randomized bursts.
module tb_class_result_streamer;
   import gcn_pkg::*;

   typedef logic [NUM_NODES-1:0][ADDR_W-1:0] addr_vec_t;
   typedef logic [NUM_NODES-1:0][IDX_W-1:0]  data_vec_t;

   typedef struct packed {
      addr_vec_t addr;
      data_vec_t data;
      data_vec_t exp_cls;
      logic      exp_err;
   } vec_t;

   typedef struct {
      int node;
      int cls;
   } ent_t;

   logic      clk = 1'b0;
   logic      rst_n;
   logic      wr_en;
   addr_vec_t wr_addr;
   data_vec_t wr_data;
   logic      rd_valid;
   logic      rd_ready;
   logic [ADDR_W-1:0] rd_node;
   logic [IDX_W-1:0]  rd_class;
   logic      rd_last;
   logic      busy;
   logic      stream_done;
   logic      err_class;
   logic      overrun;

   int total = 0;
   int bad   = 0;

   int m_mem [NUM_NODES];
   int m_err;

   class_result_streamer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .rd_node     (rd_node),
      .rd_class    (rd_class),
      .rd_last     (rd_last),
      .busy        (busy),
      .stream_done (stream_done),
      .err_class   (err_class),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic addr_vec_t alanes(input int a0, a1, a2, a3, a4, a5);
      addr_vec_t v;
      v[0] = 3'(a0); v[1] = 3'(a1); v[2] = 3'(a2);
      v[3] = 3'(a3); v[4] = 3'(a4); v[5] = 3'(a5);
      return v;
   endfunction

   function automatic data_vec_t dlanes(input int d0, d1, d2, d3, d4, d5);
      data_vec_t v;
      v[0] = 3'(d0); v[1] = 3'(d1); v[2] = 3'(d2);
      v[3] = 3'(d3); v[4] = 3'(d4); v[5] = 3'(d5);
      return v;
   endfunction

   // Reference capture: lanes in order, out-of-range lanes dropped.
   task automatic model_capture(input addr_vec_t a, input data_vec_t d);
      m_err = 0;
      for (int i = 0; i < int'(NUM_NODES); i++) begin
         if (int'(a[i]) < int'(NUM_NODES)) begin
            m_mem[int'(a[i])] = int'(d[i]);
            if (int'(d[i]) >= int'(NUM_CLASSES)) m_err = 1;
         end
      end
   endtask

   task automatic drive_burst(input addr_vec_t a, input data_vec_t d, input bit accept);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      if (accept) model_capture(a, d);
      tick();
      wr_en = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, int'(rd_valid), 0);
      check({tag, "_node"},  int'(rd_node), 0);
      check({tag, "_class"}, int'(rd_class), 0);
      check({tag, "_last"},  int'(rd_last), 0);
      check({tag, "_busy"},  int'(busy), 0);
      check({tag, "_done"},  int'(stream_done), 0);
      check({tag, "_err"},   int'(err_class), 0);
      check({tag, "_ovr"},   int'(overrun), 0);
   endtask

   // Drains one burst, either always-ready or with a 1,0,0 ready pattern.
   task automatic run_stream(input data_vec_t cls, input bit bp, input string tag);
      int n = 0;
      int k = 0;
      while (n < int'(NUM_NODES) && k < 200) begin
         rd_ready = bp ? (k % 3 == 0) : 1'b1;
         check({tag, "_valid"}, int'(rd_valid), 1);
         check({tag, "_node"},  int'(rd_node), n);
         check({tag, "_class"}, int'(rd_class), int'(cls[n]));
         check({tag, "_last"},  int'(rd_last), (n == int'(NUM_NODES) - 1) ? 1 : 0);
         check({tag, "_busy"},  int'(busy), 1);
         if (rd_ready) n++;
         k++;
         tick();
      end
      check({tag, "_budget"}, n, int'(NUM_NODES));
      check({tag, "_done_valid"}, int'(rd_valid), 0);
      check({tag, "_done_pulse"}, int'(stream_done), 1);
      check({tag, "_done_busy"},  int'(busy), 1);
      tick();
      check({tag, "_idle_done"}, int'(stream_done), 0);
      check({tag, "_idle_busy"}, int'(busy), 0);
      check({tag, "_idle_valid"}, int'(rd_valid), 0);
   endtask

   vec_t vecs [4];

   initial begin
      ent_t      exp_q [$];
      addr_vec_t ra;
      data_vec_t rd;
      int        inj;

      vecs[0].addr = alanes(0, 1, 2, 3, 4, 5);
      vecs[0].data = dlanes(0, 1, 2, 0, 1, 2);
      vecs[0].exp_cls = dlanes(0, 1, 2, 0, 1, 2);
      vecs[0].exp_err = 1'b0;
      vecs[1].addr = alanes(0, 7, 2, 3, 4, 5);
      vecs[1].data = dlanes(1, 0, 1, 3, 2, 0);
      vecs[1].exp_cls = dlanes(1, 1, 1, 3, 2, 0);
      vecs[1].exp_err = 1'b1;
      vecs[2].addr = alanes(2, 2, 2, 2, 2, 2);
      vecs[2].data = dlanes(0, 1, 2, 0, 1, 2);
      vecs[2].exp_cls = dlanes(1, 1, 2, 3, 2, 0);
      vecs[2].exp_err = 1'b0;
      vecs[3].addr = alanes(5, 4, 3, 2, 1, 0);
      vecs[3].data = dlanes(2, 2, 1, 0, 1, 0);
      vecs[3].exp_cls = dlanes(0, 1, 0, 1, 2, 2);
      vecs[3].exp_err = 1'b0;

      for (int n = 0; n < int'(NUM_NODES); n++) m_mem[n] = 0;
      m_err    = 0;
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      rd_ready = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;

      // Reset state.
      #3;
      check_zero("reset");
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rd_ready = 1'b1;
         tick();
         check("idle_valid", int'(rd_valid), 0);
         check("idle_busy",  int'(busy), 0);
      end

      // Table-driven bursts with hand-computed expected streams.
      for (int v = 0; v < 4; v++) begin
         drive_burst(vecs[v].addr, vecs[v].data, 1'b1);
         check($sformatf("vec%0d_err", v), int'(err_class), int'(vecs[v].exp_err));
         run_stream(vecs[v].exp_cls, 1'b0, $sformatf("vec%0d", v));
      end

      // Backpressure with ready pattern 1,0,0.
      drive_burst(alanes(0, 1, 2, 3, 4, 5), dlanes(2, 0, 1, 2, 0, 1), 1'b1);
      run_stream(dlanes(2, 0, 1, 2, 0, 1), 1'b1, "bp");

      // Overrun while node 2 is presented.
      drive_burst(alanes(0, 1, 2, 3, 4, 5), dlanes(1, 2, 0, 1, 2, 0), 1'b1);
      rd_ready = 1'b1;
      tick();
      tick();
      check("ovr_at_node", int'(rd_node), 2);
      check("ovr_pre", int'(overrun), 0);
      wr_en   = 1'b1;
      wr_addr = alanes(0, 1, 2, 3, 4, 5);
      wr_data = dlanes(2, 2, 2, 2, 2, 2);
      tick();
      wr_en = 1'b0;
      check("ovr_pulse", int'(overrun), 1);
      check("ovr_node3", int'(rd_node), 3);
      check("ovr_class3", int'(rd_class), 1);
      tick();
      check("ovr_clear", int'(overrun), 0);
      check("ovr_class4", int'(rd_class), 2);
      tick();
      check("ovr_class5", int'(rd_class), 0);
      check("ovr_last", int'(rd_last), 1);
      tick();
      check("ovr_done", int'(stream_done), 1);
      tick();
      // All lanes out of range: memory must still hold the first burst.
      drive_burst(alanes(7, 6, 7, 6, 7, 6), dlanes(2, 2, 2, 2, 2, 2), 1'b1);
      check("keep_err", int'(err_class), 0);
      run_stream(dlanes(1, 2, 0, 1, 2, 0), 1'b0, "keep");

      // Reset mid-stream at node 3.
      drive_burst(alanes(0, 1, 2, 3, 4, 5), dlanes(0, 1, 2, 2, 1, 0), 1'b1);
      rd_ready = 1'b1;
      tick();
      tick();
      tick();
      check("mid_node", int'(rd_node), 3);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("midrst");
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < int'(NUM_NODES); n++) m_mem[n] = 0;
      m_err = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("midrst_nodone", int'(stream_done), 0);
         check("midrst_novalid", int'(rd_valid), 0);
      end
      drive_burst(alanes(4, 6, 7, 6, 7, 6), dlanes(2, 5, 5, 5, 5, 5), 1'b1);
      check("post_err", int'(err_class), 0);
      run_stream(dlanes(0, 0, 0, 0, 2, 0), 1'b0, "post");

      // Randomized bursts against the queue-based reference.
      for (int b = 0; b < 30; b++) begin
         for (int i = 0; i < int'(NUM_NODES); i++) begin
            ra[i] = 3'($urandom_range(0, 7));
            rd[i] = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         end
         drive_burst(ra, rd, 1'b1);
         exp_q.delete();
         for (int n = 0; n < int'(NUM_NODES); n++) exp_q.push_back('{node: n, cls: m_mem[n]});
         for (int k = 0; k < 300 && exp_q.size() > 0; k++) begin
            rd_ready = 1'($urandom_range(0, 1));
            inj = ($urandom_range(0, 7) == 0) ? 1 : 0;
            if (inj != 0) begin
               wr_en   = 1'b1;
               wr_addr = 18'($urandom);
               wr_data = 18'($urandom);
            end
            check("rnd_valid", int'(rd_valid), 1);
            check("rnd_node",  int'(rd_node), exp_q[0].node);
            check("rnd_class", int'(rd_class), exp_q[0].cls);
            check("rnd_last",  int'(rd_last), (exp_q[0].node == int'(NUM_NODES) - 1) ? 1 : 0);
            check("rnd_err",   int'(err_class), m_err);
            if (rd_ready) void'(exp_q.pop_front());
            tick();
            wr_en = 1'b0;
            check("rnd_ovr", int'(overrun), inj);
         end
         check("rnd_budget", int'(exp_q.size()), 0);
         check("rnd_done", int'(stream_done), 1);
         check("rnd_done_valid", int'(rd_valid), 0);
         inj = ($urandom_range(0, 3) == 0) ? 1 : 0;
         rd_ready = 1'($urandom_range(0, 1));
         wr_en = 1'(inj);
         tick();
         wr_en = 1'b0;
         check("rnd_done_ovr", int'(overrun), inj);
         check("rnd_idle_busy", int'(busy), 0);
         check("rnd_idle_done", int'(stream_done), 0);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            rd_ready = 1'($urandom_range(0, 1));
            tick();
            check("rnd_gap_valid", int'(rd_valid), 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
